// File: rtl/inst_encoder_loader.sv
// Packs decoded MIPS fields into R/I/J instruction words and streams
// them out of a small show-ahead FIFO with sequential IMEM byte addresses.
module inst_encoder_loader #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] instIndex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [15:0] words_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   words_q, words_d;
  logic          err_q, err_d;

  logic [31:0] enc;
  logic        legal;
  logic        push;
  logic        pop;
  logic        wr_en;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    unique case (fmt)
      FMT_R:   enc = {opcode, rs, rt, rd, sa, funct};
      FMT_I:   enc = {opcode, rs, rt, imm};
      FMT_J:   enc = {opcode, instIndex};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (cnt_q < FULL);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && legal;

  // Empty slots may hold stale words; mask so the head reads zero.
  assign out_inst    = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign words_out   = words_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    words_d  = words_q;
    err_d    = push && !legal;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + 32'd4;
      words_d  = words_q + 16'd1;
    end
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= enc;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: encoding, backpressure,
// push/pop overlap, illegal drop, address wrap and mid-stream reset.
module tb_inst_encoder_loader;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam logic [31:0] BASE2 = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] instIndex;
  logic        out_ready;

  logic        in_ready, out_valid, err_illegal;
  logic [31:0] out_inst, out_addr;
  logic [15:0] words_out;

  logic        in_ready2, out_valid2, err_illegal2;
  logic [31:0] out_inst2, out_addr2;
  logic [15:0] words_out2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] ea, ea2;
  logic [15:0] ew;
  logic        eerr;

  inst_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .sa(sa), .funct(funct), .imm(imm), .instIndex(instIndex),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err_illegal(err_illegal), .words_out(words_out)
  );

  inst_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .sa(sa), .funct(funct), .imm(imm), .instIndex(instIndex),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_addr(out_addr2),
    .err_illegal(err_illegal2), .words_out(words_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check state, drive one cycle, update model.
  task automatic step(input logic v, input logic [1:0] f,
                      input logic [31:0] w, input logic r);
    logic [31:0] j1, j2;
    bit acc, pp;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("words_out", 32'(words_out), 32'(ew));
    chk("err_illegal", 32'(err_illegal), 32'(eerr));
    chk("out_addr", out_addr, ea);
    chk("out_addr_wrap", out_addr2, ea2);
    chk("dut2_valid", 32'(out_valid2), 32'(q.size() != 0));
    chk("dut2_ready", 32'(in_ready2), 32'(q.size() < DEPTH));
    chk("dut2_words", 32'(words_out2), 32'(ew));
    chk("dut2_err", 32'(err_illegal2), 32'(eerr));
    if (q.size() != 0) begin
      chk("out_inst", out_inst, q[0]);
      chk("dut2_inst", out_inst2, q[0]);
    end else begin
      chk("out_inst_empty", out_inst, 32'h0);
      chk("dut2_inst_empty", out_inst2, 32'h0);
    end
    j1 = $urandom();
    j2 = $urandom();
    in_valid  = v;
    fmt       = f;
    opcode    = w[31:26];
    rs        = j1[4:0];
    rt        = j1[9:5];
    rd        = j1[14:10];
    sa        = j1[19:15];
    funct     = j1[25:20];
    imm       = j2[15:0];
    instIndex = {j1[31:26], j2[31:12]};
    case (f)
      2'd0: begin
        rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
        sa = w[10:6]; funct = w[5:0];
      end
      2'd1: begin
        rs = w[25:21]; rt = w[20:16]; imm = w[15:0];
      end
      2'd2: instIndex = w[25:0];
      default: ;
    endcase
    out_ready = r;
    acc = v && (q.size() < DEPTH);
    pp  = r && (q.size() != 0);
    @(negedge clk);
    if (pp) begin
      void'(q.pop_front());
      ea  = ea + 32'd4;
      ea2 = ea2 + 32'd4;
      ew  = ew + 16'd1;
    end
    if (acc && f != 2'd3) q.push_back(w);
    eerr = acc && (f == 2'd3);
  endtask

  task automatic model_reset();
    q.delete();
    ea   = BASE;
    ea2  = BASE2;
    ew   = '0;
    eerr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fmt = '0;
    opcode = '0; rs = '0; rt = '0; rd = '0; sa = '0;
    funct = '0; imm = '0; instIndex = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 2'd0, 32'h0, 0);

    // encoding of one R, one I, one J word
    step(1, 2'd0, 32'h0022_1821, 0);
    step(1, 2'd1, 32'h2422_0005, 0);
    step(1, 2'd2, 32'h0800_0100, 0);
    repeat (3) step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);
    chk("words_after_enc", 32'(words_out), 32'd3);

    // fill to full, extra tuple refused, single pop frees a slot
    for (int i = 0; i < 4; i++) step(1, 2'd1, 32'h2000_0010 + i, 0);
    step(1, 2'd1, 32'h2000_0099, 0);
    step(1, 2'd1, 32'h2000_0099, 0);
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);
    repeat (3) step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);

    // overlapped push and pop at occupancy two
    step(1, 2'd2, 32'h0BAD_C0DE, 0);
    step(1, 2'd0, 32'h0085_3020, 0);
    for (int i = 0; i < 10; i++) begin
      if (i[0]) step(1, 2'd2, 32'h0C00_0000 + i, 1);
      else      step(1, 2'd1, 32'h8C85_0000 + i, 1);
    end
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);

    // illegal tuple dropped between two good ones
    step(1, 2'd0, 32'h014B_4822, 0);
    step(1, 2'd3, 32'hFFFF_FFFF, 0);
    step(1, 2'd1, 32'h3C01_1234, 0);
    step(0, 2'd0, 32'h0, 0);
    repeat (2) step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);

    // reset with three words buffered
    for (int i = 0; i < 3; i++) step(1, 2'd2, 32'h0800_0200 + i, 0);
    step(0, 2'd0, 32'h0, 0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 2'd0, 32'h0, 0);
    chk("rst_addr", out_addr, 32'hBFC0_0000);
    chk("rst_words", 32'(words_out), 32'd0);
    step(1, 2'd1, 32'h2402_000A, 0);
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
